seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Display stage that consumes the 2-bit digit-select count from the scan counter and drives a 4-digit, common-anode, multiplexed seven-segment display. It holds a double-buffered 16-bit hex value with decimal points, commits new values only at frame boundaries (select wrap 3→0) to prevent tearing, and inserts a parameterised anti-ghosting blank after every select change. It also provides optional leading-zero blanking.

## Interface
- DEAD_CYCLES, 4: clk cycles with all anodes off after each select change; legal 1..255.
- clk  in  1  rising-edge system clock.
- Reset  in  1  asynchronous reset, active-low.
- sel  in  2  digit select from scan counter; 0 = rightmost digit.
- value  in  16  four hex nibbles; value[3:0] = digit 0, value[15:12] = digit 3.
- dp  in  4  decimal-point enables, one per digit, active-high.
- load  in  1  one-cycle strobe; captures value/dp into the pending buffer.
- blank_lz  in  1  level; enables leading-zero blanking.
- an  out  4  anodes, active-low; an[i] drives digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal-point cathode, active-low.
- busy  out  1  pending buffer holds an uncommitted value.
- frame  out  1  one-cycle pulse on commit.

## Operation
- Registers: pending value/dp, active value/dp, sel_q (last sampled sel), 8-bit dead counter, FSM state.
- FSM has two states:
  - BLANK: an=4'b1111, seg=7'h7F, dp_n=1. Counter decrements. When it is 1 at an edge, go to DRIVE.
  - DRIVE: an=~(1<<sel_q). seg is the decoded active nibble for sel_q. dp_n=~active_dp[sel_q].
- Select change (sel≠sel_q), from any state: sel_q←sel, state←BLANK, counter←DEAD_CYCLES.
- Commit condition: a change with sel_q==3 and sel==0.
  - If busy, copy pending to active, pulse frame, clear busy.
  - With no pending value, commit does nothing and frame stays 0.
- load: pending←value/dp, busy←1. A second load while busy overwrites pending (last wins).
- load on the same edge as a commit: the old pending value commits, the new value becomes pending, busy stays 1.
- Non-adjacent sel jumps (e.g. 1→3) are ordinary changes. Only 3→0 commits.
- Leading-zero blanking (blank_lz=1):
  - Digit 3 is blanked if nibble3==0.
  - Digit 2 is blanked if nibbles 3,2 are all 0.
  - Digit 1 is blanked if nibbles 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7'h7F but still shows its dp.
- Decode: standard hex glyphs, lowercase b and d. Examples: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.

## Timing
- Reset values (asserted asynchronously):
  - an=4'b1111, seg=7'h7F, dp_n=1, busy=0, frame=0.
  - active/pending=0, sel_q=0, state=BLANK, counter=DEAD_CYCLES.
- After Reset deasserts with sel=0: the first DRIVE (an=4'b1110) occurs DEAD_CYCLES edges later.
- Change sampled at edge E0: an=1111 from E0; DRIVE outputs from edge E0+DEAD_CYCLES. Blank interval is exactly DEAD_CYCLES cycles.
- A further change during BLANK restarts the counter.
- All outputs are registered; there is no combinational path from inputs to outputs.
- busy rises the edge after load and falls on the commit edge. frame is high for exactly the cycle after the commit edge.
- Commit and the newly selected digit 0 use the new active value; no old-frame glyph appears after commit.

## Structure
- Shared package (seg_pkg):
  - 16 glyph constants.
  - BLANK/DRIVE state encoding.
  - SEG_OFF=7'h7F, AN_OFF=4'hF.
- Sub-module hex_to_7seg: combinational nibble→7-bit active-low decoder, instantiated once.
- Leading-zero blanking logic and the FSM live in the top module.

## Test plan
- Reset mid-DRIVE: an=1111, seg=7F, busy=0 immediately. After release with sel=0 and DEAD_CYCLES=4, an=1110 exactly 4 edges later with seg=7'b1000000.
- load value=16'h12AF, then cycle sel 0→1→2→3→0: no change before wrap. After wrap, digits 0..3 show F, A, 2, 1, with frame pulsing once.
- Two loads (16'h1111 then 16'h2222) before wrap: busy=1 throughout. Commit shows 2222 only.
- load coincident with the 3→0 edge: the prior pending value commits, busy stays 1, the new value commits on the next wrap.
- blank_lz=1, value=16'h0050: digits 3 and 2 have seg=7F, digit 1 shows 5, digit 0 shows 0. With blank_lz=0, all four digits are lit.
- Any sel change: an=1111 for exactly DEAD_CYCLES cycles. A sel change during blank restarts the count. 1→3 does not commit.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared definitions for the seg_scan_driver display stage.
// Holds the FSM state encoding, the all-off drive levels for the anodes
// and cathodes, and the sixteen active-low hex glyphs ({g,f,e,d,c,b,a}).
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low glyphs; b and d are the lowercase forms so they stay
  // distinguishable from 8 and 0.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_if: groups the display-stage signals.
//   sel      : digit select from the scan counter (0 = rightmost digit)
//   value    : four hex nibbles, value[3:0] is digit 0
//   dp       : per-digit decimal-point enables, active-high
//   load     : one-cycle strobe capturing value/dp into the pending buffer
//   blank_lz : level enabling leading-zero blanking
//   an       : anodes, active-low
//   seg      : cathodes {g,f,e,d,c,b,a}, active-low
//   dp_n     : decimal-point cathode, active-low
//   busy     : pending buffer holds an uncommitted value
//   frame    : one-cycle pulse when a pending value is committed
// master drives the request side, slave is the display driver.
interface seg_scan_if;
  logic [1:0]  sel;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        busy;
  logic        frame;

  modport master (
    output sel, value, dp, load, blank_lz,
    input  an, seg, dp_n, busy, frame
  );

  modport slave (
    input  sel, value, dp, load, blank_lz,
    output an, seg, dp_n, busy, frame
  );
endinterface

// File: rtl/seg_scan_driver_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : cathode pattern {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; all sixteen codes are listed so the default never wins.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit common-anode seven-segment driver.
// Follows an external 2-bit digit select, blanks all anodes for DEAD_CYCLES
// clocks after every select change (anti-ghosting), and shows a
// double-buffered hex value that only switches over when the select wraps
// from 3 to 0, so a frame never mixes old and new digits.
//   clk   : rising-edge system clock
//   Reset : asynchronous reset, active-low
//   bus   : seg_scan_if slave (sel/value/dp/load/blank_lz in,
//           an/seg/dp_n/busy/frame out, all outputs registered)
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input logic       clk,
  input logic       Reset,
  seg_scan_if.slave bus
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

  logic [15:0] pend_value;
  logic [15:0] act_value;
  logic [3:0]  pend_dp;
  logic [3:0]  act_dp;
  logic [1:0]  sel_q;
  logic [7:0]  dead_cnt;
  state_t      state;
  logic        busy_q;
  logic        frame_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_n_q;

  logic        sel_change;
  logic        commit;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic        lz_hide;
  logic [3:0]  drive_an;
  logic [6:0]  drive_seg;
  logic        drive_dp_n;

  // A commit only happens on the 3->0 wrap and only when something is pending.
  assign sel_change = (bus.sel != sel_q);
  assign commit     = sel_change && (sel_q == 2'd3) && (bus.sel == 2'd0) && busy_q;

  // Pick the active nibble for the current digit and decide whether it is a
  // leading zero: a digit hides only if it and every digit to its left are 0.
  always_comb begin
    nibble  = act_value[3:0];
    lz_hide = 1'b0;
    case (sel_q)
      2'd0: nibble = act_value[3:0];
      2'd1: begin
        nibble  = act_value[7:4];
        lz_hide = (act_value[15:4] == 12'h000);
      end
      2'd2: begin
        nibble  = act_value[11:8];
        lz_hide = (act_value[15:8] == 8'h00);
      end
      2'd3: begin
        nibble  = act_value[15:12];
        lz_hide = (act_value[15:12] == 4'h0);
      end
    endcase
    lz_hide = lz_hide & bus.blank_lz;
  end

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Values loaded into the output registers whenever the FSM is driving.
  // A hidden leading zero still shows its decimal point.
  always_comb begin
    drive_an   = ~(4'b0001 << sel_q);
    drive_seg  = lz_hide ? SEG_OFF : glyph;
    drive_dp_n = ~act_dp[sel_q];
  end

  // Double buffer: load always refreshes pending (last load wins); a commit
  // moves the old pending value to active. If load and commit share an edge
  // the old value commits and busy stays set for the new one.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      act_value  <= 16'h0000;
      act_dp     <= 4'h0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      frame_q <= commit;
      if (commit) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
      end
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp;
        busy_q     <= 1'b1;
      end else if (commit) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Scan FSM with registered outputs. Any select change (even during the
  // blank) restarts the dead-time count; DRIVE re-registers its outputs every
  // cycle so a blank_lz change takes effect without waiting for a new digit.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_BLANK;
      sel_q    <= 2'd0;
      dead_cnt <= DEAD_LOAD;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_n_q   <= 1'b1;
    end else if (sel_change) begin
      sel_q    <= bus.sel;
      state    <= ST_BLANK;
      dead_cnt <= DEAD_LOAD;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_n_q   <= 1'b1;
    end else begin
      case (state)
        ST_BLANK: begin
          if (dead_cnt == 8'd1) begin
            state  <= ST_DRIVE;
            an_q   <= drive_an;
            seg_q  <= drive_seg;
            dp_n_q <= drive_dp_n;
          end else begin
            dead_cnt <= dead_cnt - 8'd1;
          end
        end
        ST_DRIVE: begin
          an_q   <= drive_an;
          seg_q  <= drive_seg;
          dp_n_q <= drive_dp_n;
        end
      endcase
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.busy  = busy_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver.
// Stimulus pushes hand-computed expected outputs into a queue tagged with the
// negedge at which they must hold; a separate monitor pops and compares.
module tb_seg_scan_driver;

  localparam int DEAD = 4;

  localparam logic [13:0] MASK_DISP  = 14'h3FFC;
  localparam logic [13:0] MASK_FLAGS = 14'h0003;

  typedef struct {
    time         due;
    string       name;
    logic [13:0] exp;
    logic [13:0] mask;
  } exp_t;

  logic clk;
  logic Reset;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seg_scan_if bus ();

  seg_scan_driver #(.DEAD_CYCLES(DEAD)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every entry due at this negedge against the DUT.
  always @(negedge clk) begin
    logic [13:0] got;
    exp_t        e;
    got = {bus.an, bus.seg, bus.dp_n, bus.busy, bus.frame};
    while (sb.size() > 0 && sb[0].due <= $time) begin
      e = sb.pop_front();
      checks++;
      if (e.due != $time) begin
        errors++;
        $display("[TB] FAIL %s: entry not checked in its slot (due %0t, now %0t)", e.name, e.due, $time);
      end else if ((got & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: got an=%b seg=%b dp_n=%b busy=%b frame=%b, required an=%b seg=%b dp_n=%b busy=%b frame=%b (mask %h)",
                 e.name, got[13:10], got[9:3], got[2], got[1], got[0],
                 e.exp[13:10], e.exp[9:3], e.exp[2], e.exp[1], e.exp[0], e.mask);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Queue an expectation for the coming negedge (called at posedge+2).
  task automatic checkOutput(input string name, input logic [13:0] exp, input logic [13:0] mask);
    exp_t e;
    e.due  = $time + 3;
    e.name = name;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic checkDisp(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dpn);
    checkOutput(name, {an, seg, dpn, 2'b00}, MASK_DISP);
  endtask

  task automatic checkFlags(input string name, input logic busy, input logic frame);
    checkOutput(name, {12'h000, busy, frame}, MASK_FLAGS);
  endtask

  // One-cycle load strobe of value/dp.
  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp);
    bus.value = value;
    bus.dp    = dp;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  // Change sel and check: blank on the change edge and on the last dead
  // cycle, the frame pulse lasts one cycle, then the new digit drives.
  task automatic selStep(input string tag, input logic [1:0] s,
                         input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dpn,
                         input logic e_busy, input logic e_frame);
    bus.sel = s;
    tick();
    bus.load = 1'b0;
    checkDisp({tag, "_blank_first"}, 4'b1111, 7'h7F, 1'b1);
    checkFlags({tag, "_flags"}, e_busy, e_frame);
    for (int k = 2; k <= DEAD; k++) begin
      tick();
      if (k == 2) checkFlags({tag, "_frame_end"}, e_busy, 1'b0);
      if (k == DEAD) checkDisp({tag, "_blank_last"}, 4'b1111, 7'h7F, 1'b1);
    end
    tick();
    checkDisp({tag, "_drive"}, e_an, e_seg, e_dpn);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset        = 1'b0;
    bus.sel      = 2'd0;
    bus.value    = 16'h0000;
    bus.dp       = 4'h0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset state and first DRIVE after release.
    tick();
    checkDisp("reset_disp", 4'b1111, 7'h7F, 1'b1);
    checkFlags("reset_flags", 1'b0, 1'b0);
    Reset = 1'b1;
    tick(); tick(); tick();
    checkDisp("boot_blank", 4'b1111, 7'h7F, 1'b1);
    tick();
    checkDisp("boot_drive", 4'b1110, 7'b1000000, 1'b1);

    // 12AF with dp on digit 1: nothing changes until the wrap.
    applyStimulus(16'h12AF, 4'b0010);
    checkFlags("load_busy", 1'b1, 1'b0);
    checkDisp("load_hold", 4'b1110, 7'b1000000, 1'b1);
    selStep("pre1", 2'd1, 4'b1101, 7'b1000000, 1'b1, 1'b1, 1'b0);
    selStep("pre2", 2'd2, 4'b1011, 7'b1000000, 1'b1, 1'b1, 1'b0);
    selStep("pre3", 2'd3, 4'b0111, 7'b1000000, 1'b1, 1'b1, 1'b0);
    selStep("wrap", 2'd0, 4'b1110, 7'b0001110, 1'b1, 1'b0, 1'b1);
    selStep("dig1", 2'd1, 4'b1101, 7'b0001000, 1'b0, 1'b0, 1'b0);
    selStep("dig2", 2'd2, 4'b1011, 7'b0100100, 1'b1, 1'b0, 1'b0);
    selStep("dig3", 2'd3, 4'b0111, 7'b1111001, 1'b1, 1'b0, 1'b0);

    // Two loads before the wrap: last one wins.
    applyStimulus(16'h1111, 4'b0000);
    checkFlags("load1_busy", 1'b1, 1'b0);
    applyStimulus(16'h2222, 4'b0000);
    checkFlags("load2_busy", 1'b1, 1'b0);
    checkDisp("load2_hold", 4'b0111, 7'b1111001, 1'b1);
    selStep("wrap2", 2'd0, 4'b1110, 7'b0100100, 1'b1, 1'b0, 1'b1);

    // Load coincident with the wrap; 1->3 jumps never commit.
    applyStimulus(16'h0003, 4'b0000);
    checkFlags("lpre_busy", 1'b1, 1'b0);
    selStep("c1", 2'd1, 4'b1101, 7'b0100100, 1'b1, 1'b1, 1'b0);
    selStep("c3", 2'd3, 4'b0111, 7'b0100100, 1'b1, 1'b1, 1'b0);
    bus.value = 16'h0004;
    bus.load  = 1'b1;
    selStep("cwrap", 2'd0, 4'b1110, 7'b0110000, 1'b1, 1'b1, 1'b1);
    selStep("cnext1", 2'd1, 4'b1101, 7'b1000000, 1'b1, 1'b1, 1'b0);
    selStep("cjump3", 2'd3, 4'b0111, 7'b1000000, 1'b1, 1'b1, 1'b0);
    selStep("cwrap2", 2'd0, 4'b1110, 7'b0011001, 1'b1, 1'b0, 1'b1);

    // Leading-zero blanking on 0050, dp on digit 3.
    bus.blank_lz = 1'b1;
    applyStimulus(16'h0050, 4'b1000);
    checkFlags("lz_busy", 1'b1, 1'b0);
    checkDisp("lz_d0_refresh", 4'b1110, 7'b0011001, 1'b1);
    selStep("lz_j3", 2'd3, 4'b0111, 7'h7F, 1'b1, 1'b1, 1'b0);
    selStep("lz_wrap", 2'd0, 4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b1);
    selStep("lz_d1", 2'd1, 4'b1101, 7'b0010010, 1'b1, 1'b0, 1'b0);
    selStep("lz_d2", 2'd2, 4'b1011, 7'h7F, 1'b1, 1'b0, 1'b0);
    selStep("lz_d3", 2'd3, 4'b0111, 7'h7F, 1'b0, 1'b0, 1'b0);
    bus.blank_lz = 1'b0;
    tick();
    checkDisp("lz_off_d3", 4'b0111, 7'b1000000, 1'b0);
    selStep("lz_off_d2", 2'd2, 4'b1011, 7'b1000000, 1'b1, 1'b0, 1'b0);

    // A change during the blank restarts the dead time.
    bus.sel = 2'd1;
    tick();
    checkDisp("restart_blank", 4'b1111, 7'h7F, 1'b1);
    tick();
    tick();
    selStep("restart", 2'd3, 4'b0111, 7'b1000000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while driving with a pending value.
    applyStimulus(16'h00AB, 4'b0000);
    checkFlags("pre_rst_busy", 1'b1, 1'b0);
    checkDisp("pre_rst_drive", 4'b0111, 7'b1000000, 1'b0);
    tick();
    Reset = 1'b0;
    checkDisp("rst_async_disp", 4'b1111, 7'h7F, 1'b1);
    checkFlags("rst_async_flags", 1'b0, 1'b0);
    bus.sel = 2'd0;
    tick();
    Reset = 1'b1;
    tick(); tick(); tick();
    checkDisp("rst_rel_blank", 4'b1111, 7'h7F, 1'b1);
    tick();
    checkDisp("rst_rel_drive", 4'b1110, 7'b1000000, 1'b1);
    checkFlags("rst_rel_flags", 1'b0, 1'b0);

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
